// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath strobes.
// A memory wait that runs too long parks the FSM in ERROR until reset.
module instr_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       load,
    input  logic       store,
    input  logic       branch,
    input  logic       jal,
    input  logic       reg_write,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_en,
    output logic       pc_en,
    output logic       pc_sel,
    output logic       rf_we,
    output logic       instr_done,
    output logic       timeout_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    // The last tolerated wait cycle: a miss here trips the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     cur, nxt;
    logic       f_load, f_store, f_jal, f_branch, f_rw, f_bt;
    logic       n_load, n_store, n_jal, n_branch, n_rw, n_bt;
    logic [7:0] wait_cnt, n_wait;

    assign state = cur;

    // Instruction register captures the fetched word the cycle memory answers.
    assign ir_en = (cur == S_FETCH) && mem_ready;

    // Next-state, latched-flag and wait-counter decisions.
    always_comb begin
        nxt      = cur;
        n_load   = f_load;
        n_store  = f_store;
        n_jal    = f_jal;
        n_branch = f_branch;
        n_rw     = f_rw;
        n_bt     = f_bt;
        n_wait   = wait_cnt;
        case (cur)
            S_IDLE: begin
                if (run) begin
                    nxt    = S_FETCH;
                    n_wait = '0;
                end
            end
            S_FETCH, S_MEMORY: begin
                if (mem_ready) begin
                    nxt = (cur == S_FETCH) ? S_DECODE : S_WRITEBACK;
                end else begin
                    n_wait = wait_cnt + 8'd1;
                    if (wait_cnt == WAIT_LAST) nxt = S_ERROR;
                end
            end
            S_DECODE: begin
                // Only one class survives: load > store > jal > branch.
                n_load   = load;
                n_store  = store && !load;
                n_jal    = jal && !load && !store;
                n_branch = branch && !load && !store && !jal;
                n_rw     = reg_write;
                nxt      = S_EXECUTE;
            end
            S_EXECUTE: begin
                n_bt   = br_taken;
                n_wait = '0;
                nxt    = (f_load || f_store) ? S_MEMORY : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                n_wait = '0;
                nxt    = run ? S_FETCH : S_IDLE;
            end
            S_ERROR: nxt = S_ERROR;
            default: nxt = S_IDLE;
        endcase
    end

    // State, flags and registered strobes (decoded from the upcoming state).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur         <= S_IDLE;
            f_load      <= 1'b0;
            f_store     <= 1'b0;
            f_jal       <= 1'b0;
            f_branch    <= 1'b0;
            f_rw        <= 1'b0;
            f_bt        <= 1'b0;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            addr_sel    <= 1'b0;
            pc_en       <= 1'b0;
            pc_sel      <= 1'b0;
            rf_we       <= 1'b0;
            instr_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cur         <= nxt;
            f_load      <= n_load;
            f_store     <= n_store;
            f_jal       <= n_jal;
            f_branch    <= n_branch;
            f_rw        <= n_rw;
            f_bt        <= n_bt;
            wait_cnt    <= n_wait;
            mem_req     <= (nxt == S_FETCH) || (nxt == S_MEMORY);
            addr_sel    <= (nxt == S_MEMORY);
            mem_we      <= (nxt == S_MEMORY) && n_store;
            pc_en       <= (nxt == S_WRITEBACK);
            instr_done  <= (nxt == S_WRITEBACK);
            rf_we       <= (nxt == S_WRITEBACK) && n_rw && !n_store;
            pc_sel      <= (nxt == S_WRITEBACK) && (n_jal || (n_branch && n_bt));
            timeout_err <= timeout_err || (nxt == S_ERROR);
        end
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 15, max consecutive mem_ready-low cycles tolerated in a wait state, 1..255.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 run  in  1  enable instruction sequencing.
REQ-005 load, store, branch, jal, reg_write  in  1 each  decoded instruction class and register-write request for the instruction held in IR.
REQ-006 br_taken  in  1  branch comparison result from the ALU.
REQ-007 mem_ready  in  1  unified memory completes current access this cycle.
REQ-008 mem_req  out  1  memory access request.
REQ-009 mem_we  out  1  memory write strobe, valid only with mem_req.
REQ-010 addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
REQ-011 ir_en  out  1  instruction register load strobe.
REQ-012 pc_en  out  1  PC update strobe.
REQ-013 pc_sel  out  1  next PC: 0 = PC+4, 1 = jump/branch target.
REQ-014 rf_we  out  1  register file write enable.
REQ-015 instr_done  out  1  one-cycle retire pulse.
REQ-016 timeout_err  out  1  sticky memory timeout flag.
REQ-017 state  out  3  current FSM state encoding.

Function
REQ-018 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6; value 7 unused and returns to IDLE on the next edge.
REQ-019 IDLE: all strobes 0; go to FETCH when run=1, else stay.
REQ-020 FETCH: mem_req=1, addr_sel=0, mem_we=0; on mem_ready=1, ir_en=1 in that same cycle (combinational) and go to DECODE; else stay.
REQ-021 DECODE: one cycle; at its end, latch load, store, branch, jal, reg_write into internal flags; go to EXECUTE.
REQ-022 Latched flag priority when more than one class is set: load > store > jal > branch; lower-priority classes are cleared.
REQ-023 EXECUTE: one cycle; latch br_taken at its end; go to MEMORY if latched load or store, else WRITEBACK.
REQ-024 MEMORY: mem_req=1, addr_sel=1, mem_we=latched store; on mem_ready=1 go to WRITEBACK; else stay.
REQ-025 WRITEBACK: one cycle; pc_en=1, instr_done=1, rf_we=latched reg_write and not latched store, pc_sel=latched jal or (latched branch and latched br_taken); then FETCH if run=1, else IDLE.
REQ-026 run deasserted mid-instruction has no effect until WRITEBACK; the instruction always completes.
REQ-027 Minimum latency with mem_ready held high: 4 cycles FETCH-to-retire for non-memory instructions and 5 cycles for load/store.
REQ-028 Wait counter (8-bit): cleared on entry to FETCH or MEMORY; increments each cycle in those states with mem_ready=0.
REQ-029 When the counter reaches TIMEOUT with mem_ready still 0, go to ERROR on that edge; mem_ready=1 in the same cycle takes priority and completes normally.
REQ-030 ERROR: timeout_err=1, all other strobes 0; only reset exits ERROR.
REQ-031 All strobes other than ir_en are Moore outputs decoded from state and latched flags only.

Reset
REQ-032 rst=0 forces IDLE, clears the wait counter, latched flags, and timeout_err, and drives every output to 0 (state=0) immediately, independent of clk.
REQ-033 Reset asserted mid-access drops mem_req in the same cycle; no write is issued after reset assertion.
REQ-034 After rst deasserts, the first FETCH starts on the first edge with run=1.

Verification
REQ-035 Reset, then run=1, mem_ready=1, reg_write=1 with no class set -> states 1,2,3,5,1; rf_we=1, pc_en=1, pc_sel=0, instr_done=1 in cycle 4.
REQ-036 Load with mem_ready low for 2 cycles in MEMORY -> MEMORY held 3 cycles with addr_sel=1, mem_we=0; then WRITEBACK with rf_we=1.
REQ-037 Store, then branch with br_taken=1, then branch with br_taken=0 -> mem_we=1 in MEMORY and rf_we=0 for the store; pc_sel=1, then pc_sel=0.
REQ-038 TIMEOUT=3, mem_ready held 0 in FETCH -> ERROR entered after 3 wait cycles, timeout_err=1 stays set; run toggling has no effect until rst=0.
REQ-039 rst pulsed low while in MEMORY with store, and run=0 asserted during EXECUTE -> outputs 0 immediately and no further mem_we; without reset, the instruction retires and the FSM then enters IDLE.
